edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
// - Watches NCH asynchronous input signals and detects rising and/or falling edges per channel, selected by the mode bits.
// - Holds one pending event per channel.
// - Round-robin arbitrates the pending events onto a single valid/ready event port.
// - Sits between raw GPIO/strobe inputs and the event consumer (interrupt/timestamp logic).
// PARAMETERS
// NCH          4  number of input channels (2..16)
// SYNC_STAGES  2  synchronizer flops per channel (>=2)
// CH_W         $clog2(NCH)  channel index width (localparam, derived)
// PORTS
// clk        in   1        rising-edge clock
// rst_n      in   1        asynchronous active-low reset
// sig_in     in   NCH      raw asynchronous inputs
// mode       in   2*NCH    per-channel mode, ch i = mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
// evt_valid  out  1        event offered on evt_ch/evt_rise
// evt_ready  in   1        consumer accepts event when evt_valid && evt_ready at clk edge
// evt_ch     out  CH_W     channel index of offered event
// evt_rise   out  1        1 = rising edge, 0 = falling edge
// ovf        out  NCH      sticky per-channel overflow (event dropped)
// ovf_clr    in   1        clears all ovf bits
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - sync chains, prev regs, pending, evt_valid, evt_ch, evt_rise, ovf all clear to 0.
//   - RR pointer last = NCH-1, so ch0 has first priority.
// - Per channel: s = last sync stage; p = register of s.
//   - rise = s & ~p & mode[2i]; fall = ~s & p & mode[2i+1]; edge detection is combinational from s/p.
//   - Only one of rise/fall can be true per cycle.
// - Pending entry per channel = {pend, pend_rise}:
//   - Edge with pend=0, or with the same channel popped this cycle: pend<=1, pend_rise<=rise.
//   - Edge with pend=1 and not popped: event dropped, oldest kept, ovf[i]<=1.
//   - mode==00 on a channel clears its pend next edge; ovf is not cleared by this.
// - ovf: sticky; ovf_clr clears all bits. Set and clear in the same cycle: set wins.
// - Output register (2 states: EMPTY evt_valid=0, FULL evt_valid=1):
//   - load = any pend && (!evt_valid || evt_ready).
//   - On load, arbiter picks the first pending channel scanning (last+1) .. (last+NCH) mod NCH.
//     - evt_ch<=idx, evt_rise<=pend_rise[idx], evt_valid<=1, pend[idx] popped, last<=idx.
//   - evt_valid && evt_ready && no pend: evt_valid<=0.
//   - While evt_valid && !evt_ready: evt_ch/evt_rise are held stable, no pop, last unchanged.
//   - Throughput: one event per cycle under continuous evt_ready.
// - Latency: sig_in transition stable before edge E0 -> evt_valid=1 after edge E0+SYNC_STAGES+1.
//   - This assumes the output is empty and the channel wins arbitration.
// - Reset mid-operation: all pending and offered events are discarded, no partial event emitted.
//   - First cycles after reset produce no spurious edge, since s and p both reset to 0.
//   - An input held high through reset yields one rise event once synchronized (if mode enables rise).
// - Mode changes take effect at the next edge evaluation; an already-offered event is unaffected.
// TESTING
// - Reset, NCH=4, SYNC_STAGES=2, mode=all 01, evt_ready=1, pulse sig_in[2] 0->1 (held).
//   -> evt_valid high exactly 3 edges later, evt_ch=2, evt_rise=1, one cycle; no event on the later fall.
// - mode ch1=11, toggle sig_in[1] 1 then 0, 10 cycles apart, evt_ready=1.
//   -> two events ch1: rise=1 then rise=0; ovf=0.
// - evt_ready=0; rise on ch0, ch1, ch3 in the same cycle; then evt_ready=1.
//   -> events in order ch0, ch1, ch3, on consecutive cycles after evt_ready goes high; offered ch0 held stable while stalled.
// - evt_ready=0, mode ch0=11; ch0 rises, then falls, then rises again, each spaced 6 cycles.
//   -> ch0 rise offered, second edge pending, third dropped; ovf[0]=1.
//   -> ovf_clr pulse clears it; ovf_clr asserted in the same cycle as a new drop leaves ovf[0]=1.
// - All 4 channels edge every cycle, evt_ready=1, mode=11.
//   -> evt_ch sequence 0,1,2,3,0,... with no starvation.
//   - Assert rst_n=0 mid-stream -> evt_valid=0 and ovf=0 immediately (async); no event is output until new edges are synchronized.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Synchronizes NCH async inputs, detects mode-selected edges, and keeps one pending event per channel.
// Pending events are round-robin arbitrated onto a valid/ready port; edge to evt_valid takes SYNC_STAGES+1 cycles.
module edge_event_arbiter #(
  parameter  int NCH         = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    sig_in,
  input  logic [2*NCH-1:0]  mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic [NCH-1:0]    ovf,
  input  logic              ovf_clr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_n;

  logic [NCH-1:0]  sync_q [SYNC_STAGES];
  logic [NCH-1:0]  prev_q;
  logic [NCH-1:0]  pend_q;
  logic [NCH-1:0]  pend_rise_q;
  logic [NCH-1:0]  ovf_q;
  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] evt_ch_q;
  logic            evt_rise_q;

  logic [NCH-1:0]  s_cur;
  logic [NCH-1:0]  mode_rise;
  logic [NCH-1:0]  mode_fall;
  logic [NCH-1:0]  mode_off;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  fall;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  drop;
  logic            any_pend;
  logic            load;
  logic            sel_found;
  logic [CH_W-1:0] sel_idx;
  logic [CH_W-1:0] cand;

  // Synchronizer chain plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_cur = sync_q[SYNC_STAGES-1];

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    mode_off  = '0;
    for (int i = 0; i < NCH; i++) begin
      mode_rise[i] = mode[2*i];
      mode_fall[i] = mode[2*i+1];
      mode_off[i]  = (mode[2*i +: 2] == 2'b00);
    end
  end

  assign rise = s_cur & ~prev_q & mode_rise;
  assign fall = ~s_cur & prev_q & mode_fall;

  // Round-robin scan starting just after the last granted channel
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (int'(last_q) + k >= NCH) begin
        cand = CH_W'(int'(last_q) + k - NCH);
      end else begin
        cand = CH_W'(int'(last_q) + k);
      end
      if (!sel_found && pend_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign any_pend = |pend_q;
  assign load     = any_pend && ((state_q == EMPTY) || evt_ready);
  assign pop      = load ? (NCH'(1) << sel_idx) : '0;
  assign drop     = (rise | fall) & pend_q & ~pop;

  // A popped slot can take a new edge in the same cycle; otherwise the oldest event wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_rise_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rise[i] || fall[i]) begin
          if (!pend_q[i] || pop[i]) begin
            pend_q[i]      <= 1'b1;
            pend_rise_q[i] <= rise[i];
          end
        end else if (pop[i] || mode_off[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clr ? '0 : ovf_q) | drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      EMPTY: if (any_pend) state_n = FULL;
      FULL:  if (evt_ready && !any_pend) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ch_q   <= '0;
      evt_rise_q <= 1'b0;
      last_q     <= CH_W'(NCH-1);
    end else if (load) begin
      evt_ch_q   <= sel_idx;
      evt_rise_q <= pend_rise_q[sel_idx];
      last_q     <= sel_idx;
    end
  end

  assign evt_valid = (state_q == FULL);
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: cycle table plus hand-written stall/overflow/round-robin sequences.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [7:0] mode;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] ovf;
  logic       ovf_clr;

  int n_chk;
  int n_fail;

  edge_event_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] sig;
    logic [7:0] md;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] ch;
    logic       rise;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic rst, input logic [3:0] sig,
                              input logic [7:0] md, input logic rdy, input logic clr,
                              input logic v, input logic [1:0] ch, input logic rise,
                              input logic [3:0] ov);
    vec_t r;
    r.rst = rst; r.sig = sig; r.md = md; r.rdy = rdy; r.clr = clr;
    r.v = v; r.ch = ch; r.rise = rise; r.ovf = ov;
    for (int k = 0; k < n; k++) tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    sig_in = '0;
    mode = 8'h55;
    evt_ready = 1'b1;
    ovf_clr = 1'b0;

    // Rise on ch2 with latency 3, no event on the later fall (rise-only mode)
    add(1, 1, 4'b0000, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    add(3, 0, 4'b0100, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'b0100, 8'h55, 1, 0, 1, 2, 1, 4'h0);
    add(1, 0, 4'b0100, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    add(6, 0, 4'b0000, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    // Simultaneous rises on ch0/1/3 while stalled, drained in order
    add(1, 1, 4'b0000, 8'h55, 0, 0, 0, 0, 0, 4'h0);
    add(3, 0, 4'b1011, 8'h55, 0, 0, 0, 0, 0, 4'h0);
    add(2, 0, 4'b1011, 8'h55, 0, 0, 1, 0, 1, 4'h0);
    add(1, 0, 4'b1011, 8'h55, 1, 0, 1, 1, 1, 4'h0);
    add(1, 0, 4'b1011, 8'h55, 1, 0, 1, 3, 1, 4'h0);
    add(1, 0, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    // Both-edge mode on ch1: rise then fall 10 cycles apart
    add(1, 1, 4'b0000, 8'h0C, 1, 0, 0, 0, 0, 4'h0);
    add(3, 0, 4'b0010, 8'h0C, 1, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'b0010, 8'h0C, 1, 0, 1, 1, 1, 4'h0);
    add(6, 0, 4'b0010, 8'h0C, 1, 0, 0, 0, 0, 4'h0);
    add(3, 0, 4'b0000, 8'h0C, 1, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'b0000, 8'h0C, 1, 0, 1, 1, 0, 4'h0);
    add(1, 0, 4'b0000, 8'h0C, 1, 0, 0, 0, 0, 4'h0);
    // Input held high through reset gives exactly one rise
    add(1, 1, 4'b0001, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    add(3, 0, 4'b0001, 8'h55, 1, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'b0001, 8'h55, 1, 0, 1, 0, 1, 4'h0);
    add(2, 0, 4'b0001, 8'h55, 1, 0, 0, 0, 0, 4'h0);

    step(1);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n     = !tbl[i].rst;
      sig_in    = tbl[i].sig;
      mode      = tbl[i].md;
      evt_ready = tbl[i].rdy;
      ovf_clr   = tbl[i].clr;
      step(1);
      chk($sformatf("row%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("row%0d_ch", i), 32'(evt_ch), 32'(tbl[i].ch));
        chk($sformatf("row%0d_rise", i), 32'(evt_rise), 32'(tbl[i].rise));
      end
      chk($sformatf("row%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
    end

    // Overflow: rise offered, fall pending, second rise dropped
    sig_in = '0;
    mode = 8'h03;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    do_reset();
    sig_in[0] = 1'b1;
    step(6);
    chk("ovf_first_valid", 32'(evt_valid), 32'd1);
    chk("ovf_first_rise", 32'(evt_rise), 32'd1);
    sig_in[0] = 1'b0;
    step(6);
    chk("ovf_none_yet", 32'(ovf), 32'h0);
    sig_in[0] = 1'b1;
    step(6);
    chk("ovf_held_ch", 32'(evt_ch), 32'd0);
    chk("ovf_held_rise", 32'(evt_rise), 32'd1);
    chk("ovf_set", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'h0);
    sig_in[0] = 1'b0;
    step(2);
    chk("ovf_before_drop", 32'(ovf), 32'h0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'h1);
    evt_ready = 1'b1;
    step(1);
    chk("ovf_drain_valid", 32'(evt_valid), 32'd1);
    chk("ovf_drain_fall", 32'(evt_rise), 32'd0);
    step(1);
    chk("ovf_drain_empty", 32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'h1);

    // All channels toggling every cycle: strict rotation, then async reset
    sig_in = '0;
    mode = 8'hFF;
    evt_ready = 1'b1;
    do_reset();
    begin
      int waited;
      waited = 0;
      while (!evt_valid && waited < 10) begin
        sig_in = ~sig_in;
        step(1);
        waited++;
      end
      chk("rr_started", 32'(evt_valid), 32'd1);
      chk("rr_latency", 32'(waited), 32'd4);
    end
    chk("rr_ch_0", 32'(evt_ch), 32'd0);
    for (int k = 1; k < 9; k++) begin
      sig_in = ~sig_in;
      step(1);
      chk($sformatf("rr_valid_%0d", k), 32'(evt_valid), 32'd1);
      chk($sformatf("rr_ch_%0d", k), 32'(evt_ch), 32'(k % 4));
    end
    chk("rr_ovf_all", 32'(ovf), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_ovf", 32'(ovf), 32'h0);
    sig_in = '0;
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("post_rst_quiet_%0d", k), 32'(evt_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
